// File: rtl/target_tracker_if.sv
// Pixel stream in, committed per-frame tracking results out.
interface target_tracker_if;
  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        is_target_color;
  logic        obj_valid;
  logic [9:0]  box_x_min;
  logic [9:0]  box_x_max;
  logic [9:0]  box_y_min;
  logic [9:0]  box_y_max;
  logic [9:0]  centre_x;
  logic [9:0]  centre_y;
  logic [10:0] vel_x;
  logic [10:0] vel_y;
  logic [18:0] pix_count;
  logic        frame_done;

  modport master (
    output DE, x_pixel, y_pixel, is_target_color,
    input  obj_valid, box_x_min, box_x_max, box_y_min, box_y_max,
    input  centre_x, centre_y, vel_x, vel_y, pix_count, frame_done
  );

  modport slave (
    input  DE, x_pixel, y_pixel, is_target_color,
    output obj_valid, box_x_min, box_x_max, box_y_min, box_y_max,
    output centre_x, centre_y, vel_x, vel_y, pix_count, frame_done
  );
endinterface

// File: rtl/target_tracker.sv
// Tracks the target-colour object per frame: run-length filtered bounding box,
// pixel count, centre and frame-to-frame velocity, committed at end of frame.
module target_tracker #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned RUN_LEN    = 4,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  target_tracker_if.slave  pix
);
  localparam int unsigned XW  = 10;
  localparam int unsigned VW  = 11;
  localparam int unsigned CW  = 19;
  localparam int unsigned CSW = CW + 1;
  localparam int unsigned RW  = 4;
  localparam logic [RW-1:0] RUN_L   = RW'(RUN_LEN);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] Y_LAST  = XW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {SYNC = 2'd0, ACCUM = 2'd1, COMMIT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   run_q, run_d;
  logic [XW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prev_valid_q, prev_valid_d;
  logic            obj_valid_q, obj_valid_d;
  logic [XW-1:0]   box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
  logic [XW-1:0]   box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
  logic [XW-1:0]   centre_x_q, centre_x_d, centre_y_q, centre_y_d;
  logic [VW-1:0]   vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [CW-1:0]   pix_count_q, pix_count_d;
  logic            frame_done_q, frame_done_d;

  logic [RW-1:0]   run_base, run_inc;
  logic            active_px, qual, first_px, last_px;
  logic [XW-1:0]   x_lo, cnew_x, cnew_y;
  logic [CSW-1:0]  cnt_sum;
  logic [VW-1:0]   csum_x, csum_y;

  // Per-pixel qualification: a run restarts at column 0 and saturates at RUN_LEN.
  assign run_base  = (pix.x_pixel == '0) ? '0 : run_q;
  assign run_inc   = (run_base >= RUN_L) ? RUN_L : run_base + RW'(1);
  assign active_px = pix.DE && ((state_q == ACCUM) ||
                     ((state_q == SYNC) && (pix.x_pixel == '0) && (pix.y_pixel == '0)));
  assign qual      = active_px && pix.is_target_color && (run_inc == RUN_L);
  assign first_px  = qual && (run_base == RUN_L - RW'(1));
  assign last_px   = pix.DE && (pix.x_pixel == X_LAST) && (pix.y_pixel == Y_LAST);
  assign x_lo      = pix.x_pixel - XW'(RUN_LEN - 1);
  assign cnt_sum   = {1'b0, cnt_q} + (first_px ? CSW'(RUN_LEN) : CSW'(1));
  assign csum_x    = {1'b0, xmin_q} + {1'b0, xmax_q};
  assign csum_y    = {1'b0, ymin_q} + {1'b0, ymax_q};
  assign cnew_x    = XW'(csum_x >> 1);
  assign cnew_y    = XW'(csum_y >> 1);

  // Next-state, accumulation and commit logic.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    obj_valid_d  = obj_valid_q;
    box_x_min_d  = box_x_min_q;
    box_x_max_d  = box_x_max_q;
    box_y_min_d  = box_y_min_q;
    box_y_max_d  = box_y_max_q;
    centre_x_d   = centre_x_q;
    centre_y_d   = centre_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    pix_count_d  = pix_count_q;
    frame_done_d = 1'b0;

    if (qual) begin
      if (first_px && (x_lo < xmin_q)) xmin_d = x_lo;
      if (pix.x_pixel > xmax_q)        xmax_d = pix.x_pixel;
      if (pix.y_pixel < ymin_q)        ymin_d = pix.y_pixel;
      if (pix.y_pixel > ymax_q)        ymax_d = pix.y_pixel;
      cnt_d = cnt_sum[CW] ? CNT_MAX : cnt_sum[CW-1:0];
    end

    case (state_q)
      SYNC: begin
        run_d = '0;
        if (active_px) begin
          run_d   = pix.is_target_color ? run_inc : '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        run_d = (pix.DE && pix.is_target_color) ? run_inc : '0;
        if (last_px) state_d = COMMIT;
      end
      COMMIT: begin
        frame_done_d = 1'b1;
        pix_count_d  = cnt_q;
        if (cnt_q >= CW'(MIN_PIXELS)) begin
          obj_valid_d  = 1'b1;
          box_x_min_d  = xmin_q;
          box_x_max_d  = xmax_q;
          box_y_min_d  = ymin_q;
          box_y_max_d  = ymax_q;
          centre_x_d   = cnew_x;
          centre_y_d   = cnew_y;
          // centre_*_q only moves on valid commits, so it is the previous valid centre.
          vel_x_d      = prev_valid_q ? ({1'b0, cnew_x} - {1'b0, centre_x_q}) : '0;
          vel_y_d      = prev_valid_q ? ({1'b0, cnew_y} - {1'b0, centre_y_q}) : '0;
          prev_valid_d = 1'b1;
        end else begin
          obj_valid_d  = 1'b0;
          vel_x_d      = '0;
          vel_y_d      = '0;
          prev_valid_d = 1'b0;
        end
        run_d   = '0;
        xmin_d  = '1;
        xmax_d  = '0;
        ymin_d  = '1;
        ymax_d  = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      default: state_d = SYNC;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      run_q        <= '0;
      xmin_q       <= '1;
      xmax_q       <= '0;
      ymin_q       <= '1;
      ymax_q       <= '0;
      cnt_q        <= '0;
      prev_valid_q <= 1'b0;
      obj_valid_q  <= 1'b0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      centre_x_q   <= '0;
      centre_y_q   <= '0;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      obj_valid_q  <= obj_valid_d;
      box_x_min_q  <= box_x_min_d;
      box_x_max_q  <= box_x_max_d;
      box_y_min_q  <= box_y_min_d;
      box_y_max_q  <= box_y_max_d;
      centre_x_q   <= centre_x_d;
      centre_y_q   <= centre_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      pix_count_q  <= pix_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix.obj_valid  = obj_valid_q;
  assign pix.box_x_min  = box_x_min_q;
  assign pix.box_x_max  = box_x_max_q;
  assign pix.box_y_min  = box_y_min_q;
  assign pix.box_y_max  = box_y_max_q;
  assign pix.centre_x   = centre_x_q;
  assign pix.centre_y   = centre_y_q;
  assign pix.vel_x      = vel_x_q;
  assign pix.vel_y      = vel_y_q;
  assign pix.pix_count  = pix_count_q;
  assign pix.frame_done = frame_done_q;
endmodule
